scratchpad_read_scheduler: RTL and testbench

Sequencer that converts whole-matrix commands into per-row read requests for one scratchpad bank's read-request FIFO. It arbitrates round-robin between GEMM operand fetches (rows of A, B, C matrices to the GEMM consumer) and store writebacks (rows of one matrix to DRAM). It tracks GEMM result write-back completions so that only one GEMM is in flight per bank. It sits between the tensor-core dispatcher and the bank's rFIFO_WEN/rFIFO_wdata/rFIFO_full/gemm_complete ports.

---
 rtl/scratchpad_read_scheduler.sv | 177 +++++++++++++++++
 tb/tb_scratchpad_read_scheduler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_read_scheduler.sv
// Turns whole-matrix GEMM and store commands into per-row read requests for one
// scratchpad bank, with round-robin arbitration and single-GEMM-in-flight tracking.
module scratchpad_read_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int ROW_BYTES = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              gemm_valid,
  output logic              gemm_ready,
  input  logic [1:0]        gemm_a_sel,
  input  logic [1:0]        gemm_b_sel,
  input  logic [1:0]        gemm_c_sel,
  input  logic              store_valid,
  output logic              store_ready,
  input  logic [1:0]        store_mat_sel,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic              rFIFO_full,
  output logic              rFIFO_WEN,
  output logic [ADDR_W+5:0] rFIFO_wdata,
  input  logic              gemm_complete,
  output logic              gemm_busy,
  output logic              gemm_done,
  output logic              err_unexpected
);

  typedef enum logic [1:0] {IDLE, ISSUE_G, ISSUE_S} state_t;

  localparam logic PRIO_GEMM  = 1'b0;
  localparam logic PRIO_STORE = 1'b1;

  state_t            state_q;
  logic              prio_q;
  logic              pending_q;
  logic [1:0]        cnt_q;
  logic [1:0]        aSel_q, bSel_q, cSel_q;
  logic [1:0]        stSel_q;
  logic [ADDR_W-1:0] stAddr_q;
  logic [1:0]        row_q;
  logic [1:0]        op_q;
  logic              done_q;
  logic              err_q;

  logic              isIdle;
  logic              gemmElig;
  logic              gemmAcc;
  logic              storeAcc;
  logic              push;
  logic [1:0]        opType;
  logic [1:0]        opSel;

  assign isIdle      = (state_q == IDLE);
  assign gemmElig    = gemm_valid & ~pending_q;
  assign gemm_ready  = isIdle & ~pending_q & (~store_valid | (prio_q == PRIO_GEMM));
  assign store_ready = isIdle & (~gemmElig | (prio_q == PRIO_STORE));
  assign gemmAcc     = gemm_valid & gemm_ready;
  assign storeAcc    = store_valid & store_ready;
  assign push        = ~isIdle & ~rFIFO_full;

  assign rFIFO_WEN      = push;
  assign gemm_busy      = pending_q;
  assign gemm_done      = done_q;
  assign err_unexpected = err_q;

  // op_q walks A, B, C within a row; type code is op index plus one
  always_comb begin
    opType = 2'b11;
    opSel  = cSel_q;
    case (op_q)
      2'd0: begin
        opType = 2'b01;
        opSel  = aSel_q;
      end
      2'd1: begin
        opType = 2'b10;
        opSel  = bSel_q;
      end
      default: begin
        opType = 2'b11;
        opSel  = cSel_q;
      end
    endcase
  end

  always_comb begin
    rFIFO_wdata = '0;
    if (push) begin
      if (state_q == ISSUE_G) begin
        rFIFO_wdata = {{ADDR_W{1'b0}}, opType, opSel, row_q};
      end else begin
        rFIFO_wdata = {stAddr_q, 2'b00, stSel_q, row_q};
      end
    end
  end

  // Completion counting runs in every state; an accept later in the block
  // overrides it, which only matters when a stray pulse lands on an accept.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      prio_q    <= PRIO_GEMM;
      pending_q <= 1'b0;
      cnt_q     <= 2'd0;
      aSel_q    <= 2'd0;
      bSel_q    <= 2'd0;
      cSel_q    <= 2'd0;
      stSel_q   <= 2'd0;
      stAddr_q  <= '0;
      row_q     <= 2'd0;
      op_q      <= 2'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (gemm_complete) begin
        if (pending_q) begin
          if (cnt_q == 2'd3) begin
            pending_q <= 1'b0;
            cnt_q     <= 2'd0;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (gemmAcc) begin
            state_q   <= ISSUE_G;
            aSel_q    <= gemm_a_sel;
            bSel_q    <= gemm_b_sel;
            cSel_q    <= gemm_c_sel;
            pending_q <= 1'b1;
            cnt_q     <= 2'd0;
            prio_q    <= PRIO_STORE;
            row_q     <= 2'd0;
            op_q      <= 2'd0;
          end else if (storeAcc) begin
            state_q  <= ISSUE_S;
            stSel_q  <= store_mat_sel;
            stAddr_q <= store_addr;
            prio_q   <= PRIO_GEMM;
            row_q    <= 2'd0;
          end
        end
        ISSUE_G: begin
          if (push) begin
            if (op_q == 2'd2) begin
              op_q  <= 2'd0;
              row_q <= row_q + 2'd1;
              if (row_q == 2'd3) begin
                state_q <= IDLE;
              end
            end else begin
              op_q <= op_q + 2'd1;
            end
          end
        end
        ISSUE_S: begin
          // Running address; wraps naturally at 2^ADDR_W
          if (push) begin
            row_q    <= row_q + 2'd1;
            stAddr_q <= stAddr_q + ADDR_W'(ROW_BYTES);
            if (row_q == 2'd3) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_read_scheduler.sv
// Randomized bench for scratchpad_read_scheduler: expected request streams are
// generated per command from matrix/row arithmetic and consumed as pushes appear.
module tb_scratchpad_read_scheduler;

  localparam int ADDR_W    = 32;
  localparam int ROW_BYTES = 8;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              gemm_valid = 1'b0;
  logic              gemm_ready;
  logic [1:0]        gemm_a_sel = 2'd0;
  logic [1:0]        gemm_b_sel = 2'd0;
  logic [1:0]        gemm_c_sel = 2'd0;
  logic              store_valid = 1'b0;
  logic              store_ready;
  logic [1:0]        store_mat_sel = 2'd0;
  logic [ADDR_W-1:0] store_addr = '0;
  logic              rFIFO_full = 1'b0;
  logic              rFIFO_WEN;
  logic [ADDR_W+5:0] rFIFO_wdata;
  logic              gemm_complete = 1'b0;
  logic              gemm_busy;
  logic              gemm_done;
  logic              err_unexpected;

  scratchpad_read_scheduler #(.ADDR_W(ADDR_W), .ROW_BYTES(ROW_BYTES)) dut (
    .CLK(CLK), .nRST(nRST),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_a_sel(gemm_a_sel), .gemm_b_sel(gemm_b_sel), .gemm_c_sel(gemm_c_sel),
    .store_valid(store_valid), .store_ready(store_ready),
    .store_mat_sel(store_mat_sel), .store_addr(store_addr),
    .rFIFO_full(rFIFO_full), .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata),
    .gemm_complete(gemm_complete), .gemm_busy(gemm_busy),
    .gemm_done(gemm_done), .err_unexpected(err_unexpected)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: outstanding expected requests and GEMM bookkeeping
  logic [ADDR_W+5:0] expQ[$];
  bit mPend, mDone, mErr, mPrio, accG;
  int mCnt;

  task automatic resetModel();
    mPend = 0; mDone = 0; mErr = 0; mPrio = 0; accG = 0; mCnt = 0;
    expQ.delete();
  endtask

  // Move past the next rising edge, updating the model from what was driven
  task automatic advance();
    @(posedge CLK);
    mDone = 0;
    if (gemm_complete) begin
      if (mPend) begin
        if (mCnt == 3) begin
          mPend = 0; mCnt = 0; mDone = 1;
        end else begin
          mCnt++;
        end
      end else begin
        mErr = 1;
      end
    end
    if (accG) begin
      mPend = 1; mCnt = 0; accG = 0;
    end
    #1;
  endtask

  task automatic queueGemm(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    for (int i = 0; i < 12; i++) begin
      int k;
      logic [1:0] sel;
      logic [1:0] typ;
      logic [1:0] row;
      k   = i % 3;
      row = 2'(i / 3);
      typ = 2'(k + 1);
      sel = (k == 0) ? a : (k == 1) ? b : c;
      expQ.push_back({{ADDR_W{1'b0}}, typ, sel, row});
    end
  endtask

  task automatic queueStore(input logic [1:0] sel, input logic [ADDR_W-1:0] base);
    for (int r = 0; r < 4; r++) begin
      logic [ADDR_W-1:0] ad;
      ad = base + ADDR_W'(r * ROW_BYTES);
      expQ.push_back({ad, 2'b00, sel, 2'(r)});
    end
  endtask

  task automatic doReset();
    nRST = 1'b0;
    gemm_valid = 0; store_valid = 0; rFIFO_full = 0; gemm_complete = 0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    resetModel();
  endtask

  task automatic acceptGemm(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    bit expG, expS;
    gemm_valid = 1; gemm_a_sel = a; gemm_b_sel = b; gemm_c_sel = c;
    @(negedge CLK);
    expG = !mPend && (!store_valid || !mPrio);
    expS = !(gemm_valid && !mPend) || mPrio;
    nChecks++;
    if (gemm_ready !== expG) begin
      nFails++; $display("[TB] FAIL gemm_ready_idle: got %b expected %b", gemm_ready, expG);
    end
    nChecks++;
    if (store_ready !== expS) begin
      nFails++; $display("[TB] FAIL store_ready_vs_gemm: got %b expected %b", store_ready, expS);
    end
    nChecks++;
    if ({rFIFO_WEN, gemm_done, gemm_busy, err_unexpected} !== {1'b0, mDone, mPend, mErr}) begin
      nFails++;
      $display("[TB] FAIL idle_status_g: got %b expected %b",
               {rFIFO_WEN, gemm_done, gemm_busy, err_unexpected}, {1'b0, mDone, mPend, mErr});
    end
    if (expG) begin
      queueGemm(a, b, c);
      mPrio = 1; accG = 1;
    end
    advance();
    gemm_valid = 0;
    gemm_a_sel = 2'($urandom); gemm_b_sel = 2'($urandom); gemm_c_sel = 2'($urandom);
  endtask

  task automatic acceptStore(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
    bit expG, expS;
    store_valid = 1; store_mat_sel = sel; store_addr = addr;
    @(negedge CLK);
    expG = !mPend && (!store_valid || !mPrio);
    expS = !(gemm_valid && !mPend) || mPrio;
    nChecks++;
    if (store_ready !== expS) begin
      nFails++; $display("[TB] FAIL store_ready_idle: got %b expected %b", store_ready, expS);
    end
    nChecks++;
    if (gemm_ready !== expG) begin
      nFails++; $display("[TB] FAIL gemm_ready_vs_store: got %b expected %b", gemm_ready, expG);
    end
    nChecks++;
    if ({rFIFO_WEN, gemm_done, gemm_busy, err_unexpected} !== {1'b0, mDone, mPend, mErr}) begin
      nFails++;
      $display("[TB] FAIL idle_status_s: got %b expected %b",
               {rFIFO_WEN, gemm_done, gemm_busy, err_unexpected}, {1'b0, mDone, mPend, mErr});
    end
    if (expS) begin
      queueStore(sel, addr);
      mPrio = 0;
    end
    advance();
    store_valid = 0;
    store_mat_sel = 2'($urandom); store_addr = $urandom;
  endtask

  // Issue phase: fullMode 0 never full, 1 full on odd cycles, 2 random
  task automatic drain(input int fullMode, input int maxPush, input logic [63:0] cmask,
                       output int cycles);
    int pushes;
    int cyc;
    logic fullNow;
    pushes = 0;
    cyc = 0;
    while (pushes < maxPush && cyc < 200) begin
      fullNow = (fullMode == 1) ? cyc[0] : (fullMode == 2) ? ($urandom % 3 == 0) : 1'b0;
      rFIFO_full = fullNow;
      gemm_complete = (cyc < 64) ? cmask[cyc[5:0]] : 1'b0;
      @(negedge CLK);
      nChecks++;
      if (rFIFO_WEN !== !fullNow) begin
        nFails++; $display("[TB] FAIL push_enable: got %b expected %b (cycle %0d)", rFIFO_WEN, !fullNow, cyc);
      end
      nChecks++;
      if ({gemm_ready, store_ready} !== 2'b00) begin
        nFails++; $display("[TB] FAIL ready_in_issue: got %b expected 00", {gemm_ready, store_ready});
      end
      if (!fullNow) begin
        nChecks++;
        if (rFIFO_wdata !== expQ[0]) begin
          nFails++; $display("[TB] FAIL request_%0d: got %h expected %h", pushes, rFIFO_wdata, expQ[0]);
        end
        void'(expQ.pop_front());
        pushes++;
      end else begin
        nChecks++;
        if (rFIFO_wdata !== '0) begin
          nFails++; $display("[TB] FAIL wdata_idle_when_full: got %h expected 0", rFIFO_wdata);
        end
      end
      nChecks++;
      if ({gemm_done, gemm_busy, err_unexpected} !== {mDone, mPend, mErr}) begin
        nFails++;
        $display("[TB] FAIL issue_status: got %b expected %b",
                 {gemm_done, gemm_busy, err_unexpected}, {mDone, mPend, mErr});
      end
      advance();
      cyc++;
    end
    rFIFO_full = 0;
    gemm_complete = 0;
    cycles = cyc;
    if (pushes < maxPush) begin
      nChecks++; nFails++;
      $display("[TB] FAIL issue_timeout: got %0d pushes expected %0d", pushes, maxPush);
    end
  endtask

  task automatic completes(input int n);
    gemm_valid = 0; store_valid = 0;
    for (int p = 0; p < n; p++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        gemm_complete = (g == gap);
        @(negedge CLK);
        nChecks++;
        if ({rFIFO_WEN, gemm_done, gemm_busy, err_unexpected} !== {1'b0, mDone, mPend, mErr}) begin
          nFails++;
          $display("[TB] FAIL completion_status: got %b expected %b",
                   {rFIFO_WEN, gemm_done, gemm_busy, err_unexpected}, {1'b0, mDone, mPend, mErr});
        end
        advance();
      end
    end
    gemm_complete = 0;
    repeat (2) begin
      @(negedge CLK);
      nChecks++;
      if ({gemm_done, gemm_busy, err_unexpected} !== {mDone, mPend, mErr}) begin
        nFails++;
        $display("[TB] FAIL done_status: got %b expected %b",
                 {gemm_done, gemm_busy, err_unexpected}, {mDone, mPend, mErr});
      end
      advance();
    end
  endtask

  task automatic test_reset();
    #2;
    gemm_valid = 1; store_valid = 0; #1;
    nChecks++;
    if ({rFIFO_WEN, rFIFO_wdata, gemm_done, err_unexpected, gemm_busy} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got %b/%h/%b%b%b expected all 0",
               rFIFO_WEN, rFIFO_wdata, gemm_done, err_unexpected, gemm_busy);
    end
    nChecks++;
    if ({gemm_ready, store_ready} !== 2'b10) begin
      nFails++; $display("[TB] FAIL reset_ready_g: got %b expected 10", {gemm_ready, store_ready});
    end
    gemm_valid = 0; store_valid = 1; #1;
    nChecks++;
    if ({gemm_ready, store_ready} !== 2'b11) begin
      nFails++; $display("[TB] FAIL reset_ready_s: got %b expected 11", {gemm_ready, store_ready});
    end
    gemm_valid = 1; store_valid = 1;
    @(posedge CLK); #1;
    nChecks++;
    if ({rFIFO_WEN, gemm_busy, gemm_ready, store_ready} !== 4'b0010) begin
      nFails++;
      $display("[TB] FAIL reset_hold: got %b expected 0010", {rFIFO_WEN, gemm_busy, gemm_ready, store_ready});
    end
    doReset();
  endtask

  task automatic test_gemm();
    int cyc;
    doReset();
    acceptGemm(2'd0, 2'd1, 2'd2);
    drain(0, 12, 64'd0, cyc);
    nChecks++;
    if (cyc !== 12) begin
      nFails++; $display("[TB] FAIL gemm_issue_cycles: got %0d expected 12", cyc);
    end
    completes(4);
    acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
    drain(0, 12, 64'd0, cyc);
    completes(4);
  endtask

  task automatic test_store();
    int cyc;
    doReset();
    acceptStore(2'd3, 32'hFFFF_FFF0);
    drain(0, 4, 64'd0, cyc);
    nChecks++;
    if (cyc !== 4) begin
      nFails++; $display("[TB] FAIL store_issue_cycles: got %0d expected 4", cyc);
    end
    acceptStore(2'($urandom), $urandom);
    drain(0, 4, 64'd0, cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    doReset();
    acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
    drain(1, 12, 64'd0, cyc);
    nChecks++;
    if (cyc !== 23) begin
      nFails++; $display("[TB] FAIL backpressure_span: got %0d expected 23", cyc);
    end
    completes(4);
    acceptStore(2'($urandom), $urandom);
    drain(2, 4, 64'd0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    doReset();
    store_valid = 1;
    acceptGemm(2'd1, 2'd2, 2'd3);
    gemm_valid = 1;
    store_valid = 1;
    drain(0, 12, 64'd0, cyc);
    acceptStore(2'd2, $urandom);
    drain(0, 4, 64'b0110, cyc);
    for (int k = 0; k < 3; k++) begin
      gemm_complete = (k < 2);
      if (k == 2) begin
        gemm_a_sel = 2'd3; gemm_b_sel = 2'd0; gemm_c_sel = 2'd1;
      end
      @(negedge CLK);
      nChecks++;
      if ({gemm_done, gemm_busy, gemm_ready} !== {mDone, mPend, !mPend}) begin
        nFails++;
        $display("[TB] FAIL blocked_until_done_%0d: got %b expected %b", k,
                 {gemm_done, gemm_busy, gemm_ready}, {mDone, mPend, !mPend});
      end
      if (k == 2) begin
        queueGemm(2'd3, 2'd0, 2'd1);
        mPrio = 1; accG = 1;
      end
      advance();
    end
    gemm_valid = 0;
    gemm_complete = 0;
    drain(0, 12, 64'd0, cyc);
    completes(4);
  endtask

  task automatic test_unexpected();
    int cyc;
    doReset();
    completes(1);
    acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
    drain(0, 12, 64'h8, cyc);
    completes(3);
    nChecks++;
    if (err_unexpected !== 1'b1) begin
      nFails++; $display("[TB] FAIL err_sticky: got %b expected 1", err_unexpected);
    end
  endtask

  task automatic test_reset_mid_issue();
    int cyc;
    doReset();
    acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
    drain(0, 5, 64'd0, cyc);
    #1;
    nRST = 1'b0;
    #1;
    nChecks++;
    if ({rFIFO_WEN, rFIFO_wdata, gemm_done, err_unexpected, gemm_busy} !== '0) begin
      nFails++;
      $display("[TB] FAIL abort_outputs: got %b/%h/%b%b%b expected all 0",
               rFIFO_WEN, rFIFO_wdata, gemm_done, err_unexpected, gemm_busy);
    end
    nChecks++;
    if ({gemm_ready, store_ready} !== 2'b11) begin
      nFails++; $display("[TB] FAIL abort_ready: got %b expected 11", {gemm_ready, store_ready});
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    resetModel();
    acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
    drain(0, 12, 64'd0, cyc);
    completes(4);
  endtask

  task automatic test_random();
    int cyc;
    doReset();
    for (int it = 0; it < 30; it++) begin
      logic [63:0] cm;
      cm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (!mPend && ($urandom % 2 == 0)) begin
        acceptGemm(2'($urandom), 2'($urandom), 2'($urandom));
        drain(2, 12, cm, cyc);
      end else begin
        acceptStore(2'($urandom), $urandom);
        drain(2, 4, cm, cyc);
      end
      if (mPend && ($urandom % 3 == 0)) completes(4 - mCnt);
    end
    if (mPend) completes(4 - mCnt);
  endtask

  initial begin
    resetModel();
    test_reset();
    test_gemm();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_unexpected();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
